// File: rtl/sl_pkg.sv
// Shared definitions for the serial-line transmitter and receiver:
// state encoding, config/status field layout and rate helper.
package sl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        BIT_PRE,
        BIT_LOW,
        BIT_POST,
        PAR_GAP,
        PARITY,
        PAR_POST,
        STOP,
        STOP_POST
    } slState_t;

    localparam int CFG_PINV_BIT = 0;
    localparam int CFG_LEN_LSB  = 1;
    localparam int CFG_LEN_W    = 6;
    localparam int CFG_SEL_LSB  = 7;
    localparam int CFG_SEL_W    = 2;
    localparam int CFG_USED_W   = 9;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_CFGERR  = 3;

    localparam int LEN_MIN = 8;
    localparam int LEN_MAX = 32;

    // Wide enough to hold 2H at the slowest rate (64).
    localparam int TIMER_W = 7;

    function automatic logic [TIMER_W-1:0] half_period(input logic [CFG_SEL_W-1:0] sel);
        return 7'd4 << sel;
    endfunction

endpackage

// File: rtl/sl_tx_timer.sv
// Loadable down-counter timing each transmitter state; expire is high
// during the last cycle of a loaded interval.
module sl_tx_timer
    import sl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] loadVal,
    output logic               expire
);

    logic [TIMER_W-1:0] count;
    logic               running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= loadVal - 1'b1;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expire = running && (count == '0);

endmodule

// File: rtl/sl_transmitter.sv
// Serial-line frame transmitter: sends a 32-bit word LSB-first on the
// two-wire SL interface with parity and stop slots, one-word holding buffer.
module sl_transmitter
    import sl_pkg::*;
#(
    parameter logic [15:0] CONFIG_RST = 16'h0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] wr_config_w,
    input  logic        wr_config_enable,
    output logic [15:0] r_config_w,
    input  logic [31:0] wr_data_w,
    input  logic        wr_data_enable,
    output logic        serial_line_zeroes_a,
    output logic        serial_line_ones_a,
    output logic [15:0] status_w,
    output logic        tx_done
);

    slState_t           state, nextState;
    logic [15:0]        cfgReg, effCfg;
    logic               overrun, cfgErr;
    logic               bufFull, bufWrite;
    logic [31:0]        bufData, shiftReg, startWord;
    logic               onesPar;
    logic [5:0]         bitsLeft;
    logic [1:0]         shSel;
    logic               shPinv;
    logic               lineZ, lineO, nextZ, nextO;
    logic               expire, timerLoad;
    logic [TIMER_W-1:0] halfP, timerVal;
    logic [5:0]         wrLen;
    logic               cfgValid, cfgAccept;
    logic               lastCycle, startIdle, startFrame, overrunEvt;
    logic               unusedReserved;

    function automatic logic maskedParity(input logic [31:0] d, input logic [5:0] len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(len)) p ^= d[i];
        end
        return p;
    endfunction

    assign unusedReserved = &{1'b0, wr_config_w[15:CFG_USED_W]};

    assign wrLen     = wr_config_w[CFG_LEN_LSB +: CFG_LEN_W];
    assign cfgValid  = !wrLen[0] && (wrLen >= 6'(LEN_MIN)) && (wrLen <= 6'(LEN_MAX));
    assign cfgAccept = wr_config_enable && cfgValid;
    // A write accepted this cycle already governs a frame starting this cycle.
    assign effCfg    = cfgAccept ? {7'b0, wr_config_w[CFG_USED_W-1:0]} : cfgReg;

    assign lastCycle  = (state == STOP_POST) && expire;
    assign startIdle  = (state == IDLE) && wr_data_enable;
    assign startFrame = startIdle || (lastCycle && (bufFull || wr_data_enable));
    assign startWord  = (lastCycle && bufFull) ? bufData : wr_data_w;
    // At the final cycle a full buffer is drained, so a concurrent write refills it.
    assign bufWrite   = wr_data_enable && (state != IDLE) && (lastCycle ? bufFull : !bufFull);
    assign overrunEvt = wr_data_enable && (state != IDLE) && bufFull && !lastCycle;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (wr_data_enable) nextState = BIT_PRE;
            BIT_PRE:   if (expire) nextState = BIT_LOW;
            BIT_LOW:   if (expire) nextState = BIT_POST;
            BIT_POST:  if (expire) nextState = (bitsLeft > 6'd1) ? BIT_PRE : PAR_GAP;
            PAR_GAP:   if (expire) nextState = PARITY;
            PARITY:    if (expire) nextState = PAR_POST;
            PAR_POST:  if (expire) nextState = STOP;
            STOP:      if (expire) nextState = STOP_POST;
            STOP_POST: if (expire) nextState = (bufFull || wr_data_enable) ? BIT_PRE : IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_comb begin
        halfP     = half_period(startFrame ? effCfg[CFG_SEL_LSB +: CFG_SEL_W] : shSel);
        timerLoad = (nextState != state) && (nextState != IDLE);
        timerVal  = halfP;
        if (nextState inside {BIT_LOW, PARITY, PAR_POST, STOP}) timerVal = halfP << 1;
    end

    // Lines are registered from the next state so they track the state with no lag.
    // LEN is always even, so the zero-count parity equals the one-count parity.
    always_comb begin
        nextZ = 1'b1;
        nextO = 1'b1;
        case (nextState)
            BIT_LOW: begin
                nextZ = shiftReg[0];
                nextO = ~shiftReg[0];
            end
            PARITY: begin
                nextZ = ~onesPar ^ shPinv;
                nextO = onesPar ^ shPinv;
            end
            STOP: begin
                nextZ = 1'b0;
                nextO = 1'b0;
            end
            default: ;
        endcase
    end

    sl_tx_timer uTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timerLoad),
        .loadVal (timerVal),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cfgReg   <= CONFIG_RST;
            overrun  <= 1'b0;
            cfgErr   <= 1'b0;
            bufFull  <= 1'b0;
            bitsLeft <= '0;
            shSel    <= '0;
            shPinv   <= 1'b0;
            lineZ    <= 1'b1;
            lineO    <= 1'b1;
        end else begin
            state <= nextState;
            lineZ <= nextZ;
            lineO <= nextO;
            if (cfgAccept) cfgReg <= effCfg;
            if (wr_config_enable) cfgErr <= !cfgValid;
            if (overrunEvt) begin
                overrun <= 1'b1;
            end else if (cfgAccept) begin
                overrun <= 1'b0;
            end
            if (bufWrite) begin
                bufFull <= 1'b1;
            end else if (lastCycle) begin
                bufFull <= 1'b0;
            end
            if (startFrame) begin
                bitsLeft <= effCfg[CFG_LEN_LSB +: CFG_LEN_W];
                shSel    <= effCfg[CFG_SEL_LSB +: CFG_SEL_W];
                shPinv   <= effCfg[CFG_PINV_BIT];
            end else if ((state == BIT_POST) && expire) begin
                bitsLeft <= bitsLeft - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bufWrite) bufData <= wr_data_w;
        if (startFrame) begin
            shiftReg <= startWord;
            onesPar  <= maskedParity(startWord, effCfg[CFG_LEN_LSB +: CFG_LEN_W]);
        end else if ((state == BIT_POST) && expire) begin
            shiftReg <= shiftReg >> 1;
        end
    end

    assign serial_line_zeroes_a = lineZ;
    assign serial_line_ones_a   = lineO;
    assign r_config_w           = cfgReg;
    assign tx_done              = lastCycle;
    always_comb begin
        status_w             = '0;
        status_w[ST_BUSY]    = (state != IDLE);
        status_w[ST_FULL]    = bufFull;
        status_w[ST_OVERRUN] = overrun;
        status_w[ST_CFGERR]  = cfgErr;
    end

endmodule

// File: tb/tb_sl_transmitter.sv
// Self-checking bench for sl_transmitter: per-cycle line waveform compared
// against a frame model built from the slot rules.
module tb_sl_transmitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] wr_config_w = '0;
    logic        wr_config_enable = 1'b0;
    logic [15:0] r_config_w;
    logic [31:0] wr_data_w = '0;
    logic        wr_data_enable = 1'b0;
    logic        serial_line_zeroes_a, serial_line_ones_a;
    logic [15:0] status_w;
    logic        tx_done;

    int nChecks = 0;
    int nPassed = 0;

    logic [2:0] expQ[$];  // {tx_done, zeroes, ones} per cycle

    sl_transmitter dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wr_config_w          (wr_config_w),
        .wr_config_enable     (wr_config_enable),
        .r_config_w           (r_config_w),
        .wr_data_w            (wr_data_w),
        .wr_data_enable       (wr_data_enable),
        .serial_line_zeroes_a (serial_line_zeroes_a),
        .serial_line_ones_a   (serial_line_ones_a),
        .status_w             (status_w),
        .tx_done              (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPassed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic void pushN(input int n, input logic [1:0] v);
        for (int i = 0; i < n; i++) expQ.push_back({1'b0, v});
    endfunction

    function automatic void buildFrame(input logic [31:0] d, input int len, input int sel, input bit pinv);
        int h;
        int nOnes;
        logic pz, po;
        h = 4 << sel;
        nOnes = 0;
        for (int i = 0; i < len; i++) begin
            pushN(h, 2'b11);
            pushN(2 * h, d[i] ? 2'b10 : 2'b01);
            pushN(h, 2'b11);
            nOnes += int'(d[i]);
        end
        pz = 1'(1 ^ ((len - nOnes) % 2)) ^ pinv;
        po = 1'(nOnes % 2) ^ pinv;
        pushN(h, 2'b11);
        pushN(2 * h, {pz, po});
        pushN(2 * h, 2'b11);
        pushN(2 * h, 2'b00);
        pushN(h, 2'b11);
        expQ[expQ.size() - 1][2] = 1'b1;
    endfunction

    task automatic writeCfg(input logic [15:0] c);
        @(negedge clk);
        wr_config_w = c;
        wr_config_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_config_enable = 1'b0;
    endtask

    // Writes up to three words on consecutive cycles, then follows expQ cycle by cycle.
    task automatic watch(input string tag, input int nw, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input int ovrAt, input bit doMid, input logic [15:0] midCfg);
        int errs;
        int firstBad;
        int n;
        logic [2:0] got;
        errs = 0;
        firstBad = -1;
        n = expQ.size();
        @(negedge clk);
        wr_data_w = w0;
        wr_data_enable = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (i + 1 < nw) wr_data_w = (i == 0) ? w1 : w2;
            else wr_data_enable = 1'b0;
            if (doMid && i == 4) begin
                wr_config_w = midCfg;
                wr_config_enable = 1'b1;
            end else begin
                wr_config_enable = 1'b0;
            end
            got = {tx_done, serial_line_zeroes_a, serial_line_ones_a};
            if (got !== expQ[i] || status_w[0] !== 1'b1) begin
                errs++;
                if (firstBad < 0) firstBad = i;
            end
            if (i == ovrAt) chk({tag, "_ovr_full"}, 32'(status_w[2:1]), 32'h3);
            @(posedge clk);
            #1;
        end
        chk({tag, "_wave_errs"}, errs, 0);
        chk({tag, "_first_bad_cycle"}, firstBad, -1);
        chk({tag, "_busy_after"}, 32'(status_w[0]), 32'h0);
        chk({tag, "_lines_after"}, {30'b0, serial_line_zeroes_a, serial_line_ones_a}, 32'h3);
        expQ.delete();
    endtask

    initial begin
        logic [31:0] d;
        logic [5:0]  len6;
        logic [1:0]  sel;
        logic        pinv;
        logic [15:0] c;
        int          bad;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lines", {30'b0, serial_line_zeroes_a, serial_line_ones_a}, 32'h3);
        chk("rst_config", 32'(r_config_w), 32'h0010);
        chk("rst_status", 32'(status_w), 32'h0);
        chk("rst_tx_done", 32'(tx_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Default config: LEN 8, SEL 0; a config write mid-frame must not disturb it.
        buildFrame(32'hA5, 8, 0, 1'b0);
        watch("a5", 1, 32'hA5, 0, 0, -1, 1'b1, 16'h00C0);
        chk("mid_cfg_applied", 32'(r_config_w), 32'h00C0);

        for (int k = 0; k < 5; k++) begin
            len6 = 6'(8 + 2 * $urandom_range(0, 12));
            sel  = 2'($urandom_range(0, 1));
            pinv = 1'($urandom_range(0, 1));
            d    = $urandom;
            c    = {7'b0, sel, len6, pinv};
            writeCfg(c);
            chk($sformatf("rand%0d_cfg", k), 32'(r_config_w), 32'(c));
            buildFrame(d, int'(len6), int'(sel), pinv);
            watch($sformatf("rand%0d", k), 1, d, 0, 0, -1, 1'b0, 16'h0);
        end

        // Three back-to-back writes: two frames with no gap, third dropped.
        writeCfg(16'h0010);
        buildFrame(32'h3C, 8, 0, 1'b0);
        buildFrame(32'hC9, 8, 0, 1'b0);
        watch("b2b", 3, 32'h3C, 32'hC9, 32'h55, 2, 1'b0, 16'h0);
        chk("ovr_sticky", 32'(status_w), 32'h4);

        writeCfg(16'h0012);
        chk("len9_cfg", 32'(r_config_w), 32'h0010);
        chk("len9_status", 32'(status_w), 32'hC);
        writeCfg(16'h0044);
        chk("len34_cfg", 32'(r_config_w), 32'h0010);
        chk("len34_status", 32'(status_w), 32'hC);
        writeCfg(16'hFE21);
        chk("valid_cfg_reserved_zero", 32'(r_config_w), 32'h0021);
        chk("valid_cfg_clears", 32'(status_w), 32'h0);

        d = $urandom;
        buildFrame(d, 16, 0, 1'b1);
        watch("pinv16", 1, d, 0, 0, -1, 1'b0, 16'h0);

        writeCfg(16'h01C0);
        buildFrame(32'hDEADBEEF, 32, 3, 1'b0);
        watch("len32_sel3", 1, 32'hDEADBEEF, 0, 0, -1, 1'b0, 16'h0);

        // Reset during BIT_LOW of the first bit with a word buffered.
        writeCfg(16'h0010);
        @(negedge clk);
        wr_data_w = 32'h5A;
        wr_data_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_data_w = 32'h77;
        @(posedge clk);
        #1;
        wr_data_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_line", {30'b0, serial_line_zeroes_a, serial_line_ones_a}, 32'h1);
        chk("pre_rst_status", 32'(status_w), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_lines", {30'b0, serial_line_zeroes_a, serial_line_ones_a}, 32'h3);
        chk("rst_mid_status", 32'(status_w), 32'h0);
        chk("rst_mid_tx_done", 32'(tx_done), 32'h0);
        chk("rst_mid_config", 32'(r_config_w), 32'h0010);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (tx_done !== 1'b0 || serial_line_zeroes_a !== 1'b1 ||
                serial_line_ones_a !== 1'b1 || status_w !== 16'h0) bad++;
        end
        chk("post_rst_quiet", bad, 0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
